alu_sequencer: RTL

- Command-side controller that drives the control and operand ports of the team's 32-bit combinational ALU: operands, op[1:0], binvert and cin. It captures the ALU's ans and cout.
- Accepts commands over a valid/ready handshake. Returns results and flags over a second valid/ready handshake.
- Single-pass ops: AND, OR, ADD, SUB, SLT. Iterative op: MULU, an unsigned shift-add multiply that reuses the ALU adder once per cycle.
- Sits between the datapath issue logic and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Command and result handshake bundle between the issue logic and alu_sequencer.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf, res_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences a combinational 32-bit ALU: single-pass logic/arith ops plus an
// iterative shift-add unsigned multiply that reuses the ALU adder each cycle.
module alu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.slave   bus,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_op,
  output logic             alu_binvert,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_cout
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_carry_q, res_carry_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_err_q, res_err_d;

  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_binvert_q, alu_binvert_d;
  logic             alu_cin_q, alu_cin_d;

  logic [WIDTH-1:0] b_eff;
  logic             ovf;
  logic [WIDTH-1:0] exec_data;
  logic [WIDTH-1:0] acc_next;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_carry_d   = res_carry_q;
    res_ovf_d     = res_ovf_q;
    res_err_d     = res_err_q;
    alu_in1_d     = '0;
    alu_in2_d     = '0;
    alu_op_d      = ALU_AND;
    alu_binvert_d = 1'b0;
    alu_cin_d     = 1'b0;
    b_eff         = (op_q == OP_ADD) ? b_q : ~b_q;
    ovf           = (a_q[MSB] == b_eff[MSB]) && (alu_ans[MSB] != a_q[MSB]);
    exec_data     = '0;
    acc_next      = mplier_q[0] ? alu_ans : acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          a_d         = bus.cmd_a;
          b_d         = bus.cmd_b;
          cmd_ready_d = 1'b0;
          if (bus.cmd_op == OP_MULU) begin
            state_d   = S_MUL;
            acc_d     = '0;
            mcand_d   = bus.cmd_a;
            mplier_d  = bus.cmd_b;
            cnt_d     = '0;
            alu_in2_d = bus.cmd_a;
            alu_op_d  = ALU_ADD;
          end else begin
            state_d   = S_EXEC;
            alu_in1_d = bus.cmd_a;
            alu_in2_d = bus.cmd_b;
            case (bus.cmd_op)
              OP_AND: alu_op_d = ALU_AND;
              OP_OR:  alu_op_d = ALU_OR;
              OP_ADD: alu_op_d = ALU_ADD;
              OP_SUB, OP_SLT: begin
                alu_op_d      = ALU_ADD;
                alu_binvert_d = 1'b1;
                alu_cin_d     = 1'b1;
              end
              default: alu_op_d = ALU_AND;
            endcase
          end
        end
      end

      S_EXEC: begin
        state_d     = S_DONE;
        res_valid_d = 1'b1;
        res_carry_d = 1'b0;
        res_ovf_d   = 1'b0;
        res_err_d   = 1'b0;
        case (op_q)
          OP_AND, OP_OR: exec_data = alu_ans;
          OP_ADD, OP_SUB: begin
            exec_data   = alu_ans;
            res_carry_d = alu_cout;
            res_ovf_d   = ovf;
          end
          OP_SLT: begin
            exec_data   = {{(WIDTH-1){1'b0}}, alu_ans[MSB] ^ ovf};
            res_carry_d = alu_cout;
            res_ovf_d   = ovf;
          end
          default: res_err_d = 1'b1;
        endcase
        res_data_d = exec_data;
        res_zero_d = (exec_data == '0);
      end

      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        // Last iteration retires straight into DONE with the final partial sum.
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_data_d  = acc_next;
          res_zero_d  = (acc_next == '0);
          res_carry_d = 1'b0;
          res_ovf_d   = 1'b0;
          res_err_d   = 1'b0;
        end else begin
          alu_in1_d = acc_next;
          alu_in2_d = mcand_q << 1;
          alu_op_d  = ALU_ADD;
        end
      end

      S_DONE: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_carry_q   <= 1'b0;
      res_ovf_q     <= 1'b0;
      res_err_q     <= 1'b0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_op_q      <= '0;
      alu_binvert_q <= 1'b0;
      alu_cin_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_carry_q   <= res_carry_d;
      res_ovf_q     <= res_ovf_d;
      res_err_q     <= res_err_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_op_q      <= alu_op_d;
      alu_binvert_q <= alu_binvert_d;
      alu_cin_q     <= alu_cin_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_err   = res_err_q;
  assign alu_in1       = alu_in1_q;
  assign alu_in2       = alu_in2_q;
  assign alu_op        = alu_op_q;
  assign alu_binvert   = alu_binvert_q;
  assign alu_cin       = alu_cin_q;

endmodule
